// File: rtl/nonce_buffer_reader.sv
`default_nettype none
// ============================================================================
// Module   : nonce_buffer_reader
// Purpose  : Buffers nonces reported by the miner in a small FIFO and streams
//            each one to the host as a byte frame, LSB first, over a
//            valid/ready interface. Nonces that arrive while the FIFO is full
//            are dropped and flagged with a sticky overflow bit.
// Options  : NONCE_BUF_STATUS_EN - when defined, each frame is prefixed with
//            a status header byte {1'b1, overflow, 2'b00, level[3:0]}.
// Revision : 1.0 - initial release
// ============================================================================
module nonce_buffer_reader #(
  parameter int DEPTH      = 8,
  parameter int NONCE_BITS = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_valid,
  input  logic [NONCE_BITS-1:0]   wr_nonce,
  output logic                    out_valid,
  output logic [7:0]              out_data,
  input  logic                    out_ready,
  output logic                    overflow,
  input  logic                    clr_overflow,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int AW     = $clog2(DEPTH);
  localparam int LW     = AW + 1;
  localparam int NBYTES = NONCE_BITS / 8;
`ifdef NONCE_BUF_STATUS_EN
  localparam int HDR_BYTES = 1;
`else
  localparam int HDR_BYTES = 0;
`endif
  localparam int FRAME_LEN = NBYTES + HDR_BYTES;
  localparam int IW        = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  localparam logic [IW-1:0] LAST_IDX   = IW'(FRAME_LEN - 1);
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
  localparam logic [LW-1:0] ONE_LEVEL  = LW'(1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // FIFO storage and bookkeeping
  logic [NONCE_BITS-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q;
  logic [AW-1:0]         rd_ptr_q;
  logic [LW-1:0]         level_q;
  logic [LW-1:0]         level_d;
  logic                  overflow_q;
  logic                  overflow_d;

  // Frame sender
  state_t                state_q;
  logic [IW-1:0]         byte_idx_q;
  logic                  out_valid_q;
  logic [7:0]            out_data_q;

  // Per-cycle events
  logic                  accept;
  logic                  last_byte;
  logic                  pop;
  logic                  full;
  logic                  push;
  logic                  drop;
  logic [AW-1:0]         next_rd;
  logic [NONCE_BITS-1:0] next_nonce;
  logic [7:0]            first_byte;
  logic [7:0]            follow_byte;
`ifdef NONCE_BUF_STATUS_EN
  logic [7:0]            lvl_ext;
  logic [3:0]            lvl_sat;
`endif

  function automatic logic [7:0] nonce_byte(input logic [NONCE_BITS-1:0] n,
                                            input int k);
    return n[8*k +: 8];
  endfunction

  // Handshake events, occupancy/overflow next-state and the next byte to show
  always_comb begin
    accept    = out_valid_q && out_ready;
    last_byte = (byte_idx_q == LAST_IDX);
    pop       = accept && last_byte;
    full      = (level_q == FULL_LEVEL);
    // A full FIFO still takes a nonce when the head frame retires this cycle.
    push      = wr_valid && (!full || pop);
    drop      = wr_valid && full && !pop;

    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + ONE_LEVEL;
    end else if (pop && !push) begin
      level_d = level_q - ONE_LEVEL;
    end

    // A drop in the same cycle as a clear wins, so no loss goes unreported.
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clr_overflow) begin
      overflow_d = 1'b0;
    end

    // Head of the FIFO after this cycle. If the only stored nonce retires
    // while a new one is written, the new one is not in memory yet: bypass.
    next_rd = rd_ptr_q + AW'(pop);
    if (pop && (level_q == ONE_LEVEL)) begin
      next_nonce = wr_nonce;
    end else begin
      next_nonce = mem_q[next_rd];
    end

`ifdef NONCE_BUF_STATUS_EN
    // Header reports occupancy including the frame's own nonce.
    lvl_ext    = 8'(level_d);
    lvl_sat    = (lvl_ext > 8'd15) ? 4'hF : lvl_ext[3:0];
    first_byte = {1'b1, overflow_q, 2'b00, lvl_sat};
`else
    first_byte = nonce_byte(next_nonce, 0);
`endif

    if (last_byte) begin
      follow_byte = nonce_byte(mem_q[rd_ptr_q], 0);
    end else begin
      follow_byte = nonce_byte(mem_q[rd_ptr_q], int'(byte_idx_q) + 1 - HDR_BYTES);
    end
  end

  // Nonce storage; contents need no reset because pointers define validity
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_q[wr_ptr_q] <= wr_nonce;
    end
  end

  // Pointers, occupancy and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      rd_ptr_q   <= next_rd;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // Frame FSM with registered byte-stream outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      byte_idx_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
    end else begin
      case (state_q)
        IDLE: begin
          if (level_q != '0) begin
            state_q     <= SEND;
            byte_idx_q  <= '0;
            out_valid_q <= 1'b1;
            out_data_q  <= first_byte;
          end
        end
        SEND: begin
          if (accept) begin
            if (last_byte) begin
              byte_idx_q <= '0;
              if (level_d != '0) begin
                out_valid_q <= 1'b1;
                out_data_q  <= first_byte;
              end else begin
                state_q     <= IDLE;
                out_valid_q <= 1'b0;
              end
            end else begin
              byte_idx_q <= byte_idx_q + IW'(1);
              out_data_q <= follow_byte;
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          byte_idx_q  <= '0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign overflow  = overflow_q;
  assign level     = level_q;

endmodule
`default_nettype wire
